// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_pkg
// Brief    : Shared Y86-64 constants: register encodings, instruction codes
//            and a small destination-match helper for the register scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package y86_pkg;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'd4;

  // Instruction codes consumed by decode when deriving src/dst registers.
  typedef enum logic [3:0] {
    I_CMOVXX = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  // Number of the two destination fields naming register r (0, 1 or 2).
  function automatic logic [1:0] hits(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic [3:0] r);
    return {1'b0, a == r} + {1'b0, b == r};
  endfunction

endpackage
`default_nettype wire

// File: rtl/scb_counter.sv
`default_nettype none
// ============================================================================
// Module   : scb_counter
// Brief    : Per-register pending-write counter. Adds up to two issue
//            increments, subtracts write-back and squash releases, saturates
//            at zero and flags any release that exceeds the current count.
// Revision : 1.0 - initial release
// ============================================================================
module scb_counter #(
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic [1:0] inc,        // issue increments this cycle (0..2)
  input  logic [1:0] dec,        // write-back releases this cycle (0..2)
  input  logic [1:0] kdec,       // squash releases this cycle (0..2)
  output logic       busy,       // effective count (after write-back bypass) != 0
  output logic       underflow   // release of more than is pending
);

  localparam int SW = CNT_W + 2;

  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    up_sum;
  logic [SW-1:0]    dn_sum;
  logic [CNT_W-1:0] cnt_d;

  // Net update and zero saturation; the write-back port bypasses into busy
  // because the register file is written on the preceding negedge.
  always_comb begin
    up_sum    = SW'(cnt) + SW'(inc);
    dn_sum    = SW'(dec) + SW'(kdec);
    cnt_d     = (up_sum >= dn_sum) ? CNT_W'(up_sum - dn_sum) : '0;
    underflow = dn_sum > SW'(cnt);
    busy      = SW'(cnt) > SW'(dec);
  end

  // Counter register; flush wins over any same-cycle issue or release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (flush) cnt <= '0;
    else            cnt <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Write-pending scoreboard for the pipelined Y86-64 register file.
//            Tracks outstanding write-backs per register and the in-flight
//            instruction count, and stalls decode on hazards or a full pipe.
//            Optional macro REG_SCOREBOARD_PERF_EN adds stall_cycles and
//            issue_count performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import y86_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_valid,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  d_dstE,
  input  logic [3:0]  d_dstM,
  output logic        d_stall,
  input  logic        w_valid,
  input  logic [3:0]  w_dstE,
  input  logic [3:0]  w_dstM,
  input  logic        k_valid,
  input  logic [3:0]  k_dstE,
  input  logic [3:0]  k_dstM,
  input  logic        flush,
  output logic [1:0]  inflight,
  output logic        err
`ifdef REG_SCOREBOARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] issue_count
`endif
);

  logic        issue;
  logic [15:0] busy;       // bit 15 (REG_NONE) is never busy
  logic [14:0] uflow;
  logic        full;
  logic        src_a_busy;
  logic        src_b_busy;
  logic [2:0]  if_up;
  logic [2:0]  if_dn;
  logic        if_uflow;
  logic [1:0]  inflight_d;

  assign busy[15] = 1'b0;

  generate
    for (genvar r = 0; r < 15; r++) begin : g_reg
      localparam logic [3:0] R = 4'(r);
      logic [1:0] inc_r;
      logic [1:0] dec_r;
      logic [1:0] kdec_r;

      assign inc_r  = issue   ? hits(d_dstE, d_dstM, R) : 2'd0;
      assign dec_r  = w_valid ? hits(w_dstE, w_dstM, R) : 2'd0;
      assign kdec_r = k_valid ? hits(k_dstE, k_dstM, R) : 2'd0;

      scb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .inc       (inc_r),
        .dec       (dec_r),
        .kdec      (kdec_r),
        .busy      (busy[r]),
        .underflow (uflow[r])
      );
    end
  endgenerate

  // Hazard and capacity stall; a release this cycle frees a pipeline slot.
  always_comb begin
    src_a_busy = (d_srcA != REG_NONE) && busy[d_srcA];
    src_b_busy = (d_srcB != REG_NONE) && busy[d_srcB];
    full       = (inflight == 2'(MAX_INFLIGHT)) && !w_valid && !k_valid;
    d_stall    = d_valid && (src_a_busy || src_b_busy || full);
    issue      = d_valid && !d_stall;
  end

  // In-flight next value with zero saturation and underflow detection.
  always_comb begin
    if_up      = {1'b0, inflight} + {2'b00, issue};
    if_dn      = {2'b00, w_valid} + {2'b00, k_valid};
    if_uflow   = if_dn > {1'b0, inflight};
    inflight_d = (if_up >= if_dn) ? 2'(if_up - if_dn) : 2'd0;
  end

  // In-flight counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     inflight <= 2'd0;
    else if (flush) inflight <= 2'd0;
    else            inflight <= inflight_d;
  end

  // Sticky protocol-error flag; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err <= 1'b0;
    else if (!flush && (|uflow || if_uflow)) err <= 1'b1;
  end

`ifdef REG_SCOREBOARD_PERF_EN
  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else if (flush) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      stall_cycles <= stall_cycles + {31'd0, d_stall};
      issue_count  <= issue_count + {31'd0, issue};
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
# reg_scoreboard

Write-pending scoreboard for the pipelined Y86-64 register file. It tracks, per architectural register, how many issued instructions still owe a write-back. It stalls decode when a source operand has an outstanding producer, or when the pipeline's in-flight limit is reached. It sits beside the decode stage: decode presents sources and destinations, and write-back and squash logic return destinations when the writes complete or are cancelled.

## Interface
Parameters:
- MAX_INFLIGHT, 3: maximum issued-but-unreleased instructions (stages E, M, W).
- CNT_W, 3: width of each per-register pending counter; must hold 2*MAX_INFLIGHT.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- d_valid  in  1  decode holds a valid instruction.
- d_srcA, d_srcB  in  4 each  registers read at decode; 4'hF = none.
- d_dstE, d_dstM  in  4 each  registers written at write-back; 4'hF = none.
- d_stall  out  1  combinational; decode must hold its instruction this cycle.
- w_valid  in  1  write-back completes one instruction this cycle.
- w_dstE, w_dstM  in  4 each  destinations being released by write-back.
- k_valid  in  1  one squashed instruction releases its destinations.
- k_dstE, k_dstM  in  4 each  destinations of the squashed instruction.
- flush  in  1  synchronous clear of all scoreboard state.
- inflight  out  2  current in-flight instruction count.
- err  out  1  sticky protocol-error flag.

## Operation
- Issue: issue = d_valid & ~d_stall. On issue, increment cnt[d_dstE] and cnt[d_dstM], and increment inflight by 1.
  - If d_dstE == d_dstM (popq %rsp), that register increments by 2.
  - Destination 4'hF is ignored.
- Release: for w_valid and for k_valid independently, decrement cnt[dstE] and cnt[dstM], and decrement inflight by 1 per port.
  - cmovxx with cnd=0 is still released; the scoreboard does not see cnd.
- Net update per register: +issue terms −w terms −k terms, all applied in one cycle. A simultaneous issue and release on the same register nets to zero.
- Effective count: eff[r] = cnt[r] minus this cycle's w-port releases of r. The register file writes on negedge, so decode sees the value in the same cycle.
- d_stall = d_valid & ((srcA != F & eff[srcA] != 0) | (srcB != F & eff[srcB] != 0) | (inflight == MAX_INFLIGHT & ~w_valid & ~k_valid)).
- err set (sticky) on any decrement of a zero count, or on inflight underflow. The offending counter saturates at 0.
- flush: counters ← 0 and inflight ← 0 next edge. flush overrides issue and release in the same cycle and does not clear err.

## Timing
- Reset values: all cnt = 0, inflight = 0, err = 0. d_stall follows combinationally from inputs, so it is 0 whenever d_valid = 0.
- d_stall has zero latency (same-cycle combinational path). Counters and inflight update at the posedge following issue or release.
- Producer issued in cycle t: a dependent instruction decoded in t+1..t+2 stalls. It proceeds in t+3, when the producer is in W and the write-back bypass clears eff.
- rst_n asserted mid-operation clears all state asynchronously. The surrounding pipeline is reset by the same signal.

## Configuration
- REG_SCOREBOARD_PERF_EN defined: adds outputs stall_cycles (32) and issue_count (32).
  - Both reset to 0 and clear on flush.
  - stall_cycles increments each cycle with d_stall = 1; issue_count increments on each issue.
  - Both wrap at 2^32.
- Not defined: these ports and registers are absent, and behaviour is otherwise identical.

## Structure
- Shared package y86_pkg holds:
  - REG_NONE = 4'hF and REG_RSP = 4'd4.
  - The icode constants (CMOVXX 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, CALL 8, RET 9, PUSHQ A, POPQ B) used by decode to derive src/dst.
- Sub-module scb_counter: one CNT_W up/down counter with inputs inc[1:0] and dec[1:0], zero-saturation and an underflow flag. It is instantiated 15 times (registers 0–14).

## Test plan
- Reset, then d_valid = 1 with srcA = 3, srcB = F → d_stall = 0; err = 0; inflight = 0.
- Issue irmovq (dstE = 2); next two cycles decode addq with srcA = 2 → d_stall = 1 both cycles. In the cycle with w_valid = 1, w_dstE = 2 → d_stall = 0. cnt[2] returns to 0.
- Issue popq %rsp (dstE = dstM = 4) → cnt[4] = 2. One w release with both dst = 4 → cnt[4] = 0. A pushq decoded that cycle is not stalled.
- Three back-to-back independent issues → inflight = 3. A fourth with no release → d_stall = 1; with k_valid the same cycle → issues and inflight stays 3.
- Issue dstE = 5, then flush in the same cycle as a w release of 5 → all cnt = 0, inflight = 0, err = 0.
- w_valid with w_dstE = 7 while cnt[7] = 0 → err = 1 and stays 1 through a later flush; cleared only by rst_n.
